// File: rtl/riscv_pkg.sv
// Shared decode-stage types: immediate formats, opcodes, the canonical NOP
// and the decode hazard controller state encoding.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/rs_usage_decode.sv
// Opcode classifier: which source registers an instruction reads and which
// immediate format it carries. Purely combinational.
module rs_usage_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       use_rs1,
  output logic       use_rs2,
  output imm_sel_e   imm_sel
);

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_sel = IMM_NONE;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        use_rs1 = 1'b1;
        imm_sel = IMM_I;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_sel = IMM_S;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_sel = IMM_B;
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JAL:            imm_sel = IMM_J;
      OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode stage sequencer: IF/ID register, load-use stall, memory freeze,
// redirect flush and saturating stall/flush counters.
module decode_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic [31:0]      id_inst,
  output logic [XLEN-1:0]  id_pc,
  output logic             id_valid,
  output imm_sel_e         imm_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_e state, state_nxt;
  logic        use_rs1, use_rs2, hazard;
  logic        do_flush, do_stall, bubble_raw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  rs_usage_decode u_rs_usage_decode (
    .opcode  (id_inst[6:0]),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .imm_sel (imm_sel)
  );

  assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                  ((use_rs1 && (id_inst[19:15] == ex_rd)) ||
                   (use_rs2 && (id_inst[24:20] == ex_rd)));

  // Control decision: redirect > mem_busy > flush capture > load-use > advance
  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b1;
    ifid_write = 1'b0;
    bubble_raw = 1'b0;
    do_flush   = 1'b0;
    do_stall   = 1'b0;
    if (ex_redirect) begin
      bubble_raw = 1'b1;
      do_flush   = 1'b1;
      state_nxt  = FLUSH;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
    end else if (state == FLUSH) begin
      ifid_write = 1'b1;
      bubble_raw = 1'b1;
      state_nxt  = RUN;
    end else if ((state == RUN) && hazard) begin
      // LU_STALL skips this branch so each load-use costs exactly one bubble
      pc_write   = 1'b0;
      bubble_raw = 1'b1;
      do_stall   = 1'b1;
      state_nxt  = LU_STALL;
    end else begin
      ifid_write = 1'b1;
      state_nxt  = RUN;
    end
  end

  assign idex_bubble = bubble_raw || !id_valid;

  // IF/ID register and counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      id_inst   <= NOP_INST;
      id_pc     <= '0;
      id_valid  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (do_flush) begin
        id_inst   <= NOP_INST;
        id_valid  <= 1'b0;
        flush_cnt <= sat_inc(flush_cnt);
      end else if (ifid_write) begin
        id_inst  <= if_inst;
        id_pc    <= if_pc;
        id_valid <= 1'b1;
      end
      if (do_stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
